// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: two-master, one-slave word bus arbiter.
// Fixed priority (PRIO_MASTER) with a starvation guard: after MAX_RUN
// consecutive accepted transfers by the priority master while the other
// master waits, the other master wins the next contended cycle.
// Grant is locked to the owner while the slave stalls, so a transfer is
// never torn between masters.
//
// Ports:
//   i_clk                  bus clock, rising edge
//   i_reset                asynchronous active-low reset
//   i_m{0,1}_address/read/write/writedata/byteenable   master requests
//   o_m{0,1}_waitrequest   master stall (1 whenever not granted)
//   o_m{0,1}_readdata      slave read data, broadcast to both masters
//   o_s_address/read/write/writedata/byteenable        slave request
//   i_s_waitrequest        slave stall
//   i_s_readdata           slave read data (zero-latency)
//   o_grant                one-hot current owner, 00 when idle
//   o_stat_acc0/acc1/wait  transfer/wait counters (only with ARB_STATS_EN)
//
// Optional feature macro: ARB_STATS_EN adds the statistics counters.
module avalon_bus_arbiter #(
    parameter int PRIO_MASTER = 0,
    parameter int MAX_RUN     = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_m0_address,
    input  logic              i_m0_read,
    input  logic              i_m0_write,
    input  logic [31:0]       i_m0_writedata,
    input  logic [3:0]        i_m0_byteenable,
    output logic              o_m0_waitrequest,
    output logic [31:0]       o_m0_readdata,
    input  logic [ADDR_W-1:0] i_m1_address,
    input  logic              i_m1_read,
    input  logic              i_m1_write,
    input  logic [31:0]       i_m1_writedata,
    input  logic [3:0]        i_m1_byteenable,
    output logic              o_m1_waitrequest,
    output logic [31:0]       o_m1_readdata,
    output logic [ADDR_W-1:0] o_s_address,
    output logic              o_s_read,
    output logic              o_s_write,
    output logic [31:0]       o_s_writedata,
    output logic [3:0]        o_s_byteenable,
    input  logic              i_s_waitrequest,
    input  logic [31:0]       i_s_readdata,
    output logic [1:0]        o_grant
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       o_stat_acc0,
    output logic [31:0]       o_stat_acc1,
    output logic [31:0]       o_stat_wait
`endif
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [1:0] PRIO_OH  = (PRIO_MASTER != 0) ? 2'b10 : 2'b01;
    localparam logic [1:0] NPRIO_OH = ~PRIO_OH;
    localparam logic [3:0] RUN_MAX  = 4'(MAX_RUN);

    state_t     r_state, w_next;
    logic [3:0] r_run_cnt, w_run_next;
    // Stays low until the first clock edge after reset release, keeping
    // every output in its reset value for that window.
    logic       r_active;
    logic       w_req0, w_req1, w_req_np, w_greq, w_acc, w_acc_p, w_acc_np;
    logic [1:0] w_grant;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= IDLE;
            r_run_cnt <= '0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_run_cnt <= w_run_next;
            r_active  <= 1'b1;
        end
    end

    always_comb begin
        w_req0   = i_m0_read | i_m0_write;
        w_req1   = i_m1_read | i_m1_write;
        w_req_np = (PRIO_MASTER != 0) ? w_req0 : w_req1;
        w_grant  = !r_active          ? 2'b00 :
                   (r_state == OWN0)  ? 2'b01 :
                   (r_state == OWN1)  ? 2'b10 :
                   (w_req0 && w_req1) ? ((r_run_cnt == RUN_MAX) ? NPRIO_OH : PRIO_OH) :
                                        {w_req1, w_req0};
        w_greq   = |(w_grant & {w_req1, w_req0});
        w_acc    = w_greq & ~i_s_waitrequest;
        w_acc_p  = w_acc && (w_grant == PRIO_OH);
        w_acc_np = w_acc && (w_grant == NPRIO_OH);
    end

    // A stalled granted request locks the bus; anything else (acceptance,
    // no grant, or an owner abandoning its request) returns to IDLE.
    always_comb begin
        w_next     = (w_greq && i_s_waitrequest) ? (w_grant[1] ? OWN1 : OWN0) : IDLE;
        w_run_next = (!w_req_np || w_acc_np)          ? 4'd0 :
                     (w_acc_p && r_run_cnt != RUN_MAX) ? r_run_cnt + 4'd1 :
                                                         r_run_cnt;
    end

    always_comb begin
        o_grant          = w_grant;
        o_s_address      = w_grant[0] ? i_m0_address    : w_grant[1] ? i_m1_address    : '0;
        o_s_read         = w_grant[0] ? i_m0_read       : w_grant[1] ? i_m1_read       : 1'b0;
        o_s_write        = w_grant[0] ? i_m0_write      : w_grant[1] ? i_m1_write      : 1'b0;
        o_s_writedata    = w_grant[0] ? i_m0_writedata  : w_grant[1] ? i_m1_writedata  : '0;
        o_s_byteenable   = w_grant[0] ? i_m0_byteenable : w_grant[1] ? i_m1_byteenable : '0;
        o_m0_waitrequest = w_grant[0] ? i_s_waitrequest : 1'b1;
        o_m1_waitrequest = w_grant[1] ? i_s_waitrequest : 1'b1;
        o_m0_readdata    = i_s_readdata;
        o_m1_readdata    = i_s_readdata;
    end

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_acc0, r_stat_acc1, r_stat_wait;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_stat_acc0 <= '0;
            r_stat_acc1 <= '0;
            r_stat_wait <= '0;
        end else begin
            if (w_acc && w_grant[0]) r_stat_acc0 <= r_stat_acc0 + 32'd1;
            if (w_acc && w_grant[1]) r_stat_acc1 <= r_stat_acc1 + 32'd1;
            if ((w_req0 && !w_grant[0]) || (w_req1 && !w_grant[1]))
                r_stat_wait <= r_stat_wait + 32'd1;
        end
    end

    assign o_stat_acc0 = r_stat_acc0;
    assign o_stat_acc1 = r_stat_acc1;
    assign o_stat_wait = r_stat_wait;
`endif
endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the 32-bit word-addressed memory bus (address/read/write/waitrequest/writedata/byteenable/readdata) shared by `mips_cpu_bus` and the RAM model.
- Master 0 is the CPU. Master 1 is the test loader/monitor port, which preloads or inspects RAM while the CPU runs.
- Uses fixed priority with a starvation guard. Grant is held across slave stalls so transfers are never torn.

Parameters:
- PRIO_MASTER, 0, index of the high-priority master (0 or 1).
- MAX_RUN, 4, max consecutive accepted transfers by the priority master while the other master is waiting; range 1..15.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  bus clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- m0_address  in  ADDR_W  master 0 address.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  32  master 0 write data.
- m0_byteenable  in  4  master 0 byte lanes.
- m0_waitrequest  out  1  master 0 stall.
- m0_readdata  out  32  master 0 read data.
- m1_*  same set as m0_*, for master 1.
- s_address  out  ADDR_W  slave address.
- s_read  out  1  slave read.
- s_write  out  1  slave write.
- s_writedata  out  32  slave write data.
- s_byteenable  out  4  slave byte lanes.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  32  slave read data.
- grant  out  2  one-hot current owner; 00 when idle.

Behaviour:
- Request definitions:
  - req_i = mi_read | mi_write.
  - A transfer is accepted in a cycle where the granted master requests and s_waitrequest=0.
- Reset (reset=0, async):
  - lock=0, owner=0, run_cnt=0, grant=00.
  - s_read=s_write=0; s_address, s_writedata, s_byteenable = 0.
  - m0_waitrequest=m1_waitrequest=1.
  - Outputs hold these values until the first clk edge after reset deasserts.
- States:
  - IDLE: lock=0.
  - OWN0 / OWN1: lock=1, the transfer of that master is stalled.
- Grant selection (combinational, zero added latency when the bus is free):
  - If lock=1, grant = owner.
  - Else if only one master requests, that master is granted.
  - Else if both request:
    - If run_cnt==MAX_RUN, the non-priority master is granted.
    - Otherwise the PRIO_MASTER is granted.
  - Else (no requests), grant=00.
- Datapath:
  - The granted master's address, read, write, writedata and byteenable drive s_*. With no grant, s_read=s_write=0 and the other s_* fields are 0.
  - Granted master: mi_waitrequest = s_waitrequest.
  - Non-granted master: mi_waitrequest = 1.
  - s_readdata is broadcast to both mi_readdata. It is valid only to the master whose read is accepted that cycle (zero-latency slave read).
- State transitions at each clk edge:
  - Granted, requesting and s_waitrequest=1: lock=1, owner=granted (enter OWN0/OWN1).
  - Transfer accepted: lock=0 (return to IDLE).
  - Locked owner drops its request while stalled (protocol violation): lock=0 and the transfer is abandoned. Masters must hold their request while waitrequest=1.
- run_cnt (4-bit):
  - Increments on each accepted transfer by PRIO_MASTER while the other master requests; saturates at MAX_RUN.
  - Clears to 0 on any accepted transfer by the non-priority master.
  - Clears to 0 in any cycle where the non-priority master does not request.
- Boundary conditions:
  - Both masters request in the same cycle from IDLE: the priority master wins.
  - A lock set while the other master raises its request persists until the locked transfer is accepted. The switch takes effect the cycle after acceptance.
  - MAX_RUN=1 gives strict alternation under contention.
  - reset asserted mid-transfer aborts it immediately; no write reaches the slave after reset falls.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds outputs stat_acc0, stat_acc1 (32-bit): accepted transfers per master.
  - Adds output stat_wait (32-bit): cycles where a master requests and is not granted.
  - All three clear on reset and wrap modulo 2^32.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset with m0_read=1 held → grant=00, s_read=0, m0_waitrequest=1 until reset rises; after reset, s_address=m0_address in the same cycle.
- m0_read @0x40 and m1_write @0x80 (data 0xDEADBEEF) together, s_waitrequest=0, PRIO_MASTER=0 → m0 read accepted first; m1 write accepted next cycle; RAM[0x80]=0xDEADBEEF.
- m0 read with s_waitrequest=1 for 3 cycles while m1 starts requesting in stall cycle 1 → grant stays 01 through all stall cycles; m1_waitrequest=1; m1 granted the cycle after m0 acceptance.
- MAX_RUN=4, both masters request continuously, s_waitrequest=0 → grant pattern 01,01,01,01,10 repeating.
- Only m1 requests (m1_write 0x12345678 @0x10, byteenable 4'b0011) → s_write=1 the same cycle; only low 2 bytes of RAM[0x10] updated; grant=10.
- ARB_STATS_EN defined, run the MAX_RUN scenario for 10 cycles → stat_acc0=8, stat_acc1=2, stat_wait=10.
